glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_pkg.sv | 23 ++
 rtl/trigger_sync.sv | 34 +++
 rtl/glitch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_glitch_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types for the glitch sequencer: FSM state encoding, force_state
// constants and a phase-length helper.
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    DELAY     = 3'd2,
    PULSE     = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam logic [1:0] FORCE_LOW  = 2'd0;
  localparam logic [1:0] FORCE_HIGH = 2'd1;
  localparam logic [1:0] AUTO       = 2'd2;

  // A phase of max(v,1) cycles is counted down from this value to zero.
  function automatic logic [31:0] phase_load(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/trigger_sync.sv
// Brings the asynchronous trigger pin into the clk domain, applies the
// optional inversion and emits a registered one-cycle qualified edge.
module trigger_sync (
  input  logic clk,
  input  logic rst,
  input  logic trigger_i,
  input  logic invert_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;
  logic level;

  assign level  = sync2_q ^ invert_i;
  assign edge_o = edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= trigger_i;
      sync2_q <= sync1_q;
      prev_q  <= level;
      edge_q  <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-qualified glitch pulse sequencer: delay, N pulses separated by gaps,
// an optional watchdog, sticky status flags and a registered output drive.
module glitch_sequencer
  import glitch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger_in,
  input  logic        invert_trigger,
  input  logic        armed,
  input  logic        reset_glitcher,
  input  logic        vstart,
  input  logic [1:0]  force_state,
  input  logic [31:0] glitch_delay,
  input  logic [31:0] glitch_width,
  input  logic [31:0] glitch_count,
  input  logic [31:0] glitch_gap,
  input  logic [31:0] glitch_max,
  output logic        glitch_out,
  output logic        glitched,
  output logic        finished
);

  state_e      state_q,    state_d;
  logic [31:0] cnt_q,      cnt_d;
  logic [31:0] pulses_q,   pulses_d;
  logic [31:0] wd_q,       wd_d;
  logic [31:0] width_q,    width_d;
  logic [31:0] gap_q,      gap_d;
  logic [31:0] max_q,      max_d;
  logic        glitch_q,   glitch_d;
  logic        glitched_q, glitched_d;
  logic        finished_q, finished_d;
  logic        trig_edge;
  logic        wd_hit;

  trigger_sync u_trigger_sync (
    .clk      (clk),
    .rst      (rst),
    .trigger_i(trigger_in),
    .invert_i (invert_trigger),
    .edge_o   (trig_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      pulses_q   <= 32'd0;
      wd_q       <= 32'd0;
      width_q    <= 32'd0;
      gap_q      <= 32'd0;
      max_q      <= 32'd0;
      glitch_q   <= 1'b0;
      glitched_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulses_q   <= pulses_d;
      wd_q       <= wd_d;
      width_q    <= width_d;
      gap_q      <= gap_d;
      max_q      <= max_d;
      glitch_q   <= glitch_d;
      glitched_q <= glitched_d;
      finished_q <= finished_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    wd_d     = wd_q;
    width_d  = width_q;
    gap_d    = gap_q;
    max_d    = max_q;
    wd_hit   = 1'b0;

    // wd_q holds the cycles elapsed since the trigger-edge cycle.
    if (state_q inside {DELAY, PULSE, GAP}) begin
      wd_d   = (wd_q == 32'hFFFF_FFFF) ? wd_q : wd_q + 32'd1;
      wd_hit = (max_q != 32'd0) && (({1'b0, wd_q} + 33'd1) >= {1'b0, max_q});
    end

    case (state_q)
      IDLE: begin
        if (armed) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!armed) begin
          state_d = IDLE;
        end else if (trig_edge) begin
          width_d  = glitch_width;
          gap_d    = glitch_gap;
          max_d    = glitch_max;
          pulses_d = phase_load(glitch_count);
          wd_d     = 32'd1;
          if (glitch_max == 32'd1) begin
            state_d = DONE;
          end else if (glitch_delay == 32'd0) begin
            state_d = PULSE;
            cnt_d   = phase_load(glitch_width);
          end else begin
            state_d = DELAY;
            cnt_d   = glitch_delay - 32'd1;
          end
        end
      end
      DELAY: begin
        if (cnt_q == 32'd0) begin
          state_d = PULSE;
          cnt_d   = phase_load(width_q);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PULSE: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (pulses_q == 32'd0) begin
          state_d = DONE;
        end else begin
          state_d  = GAP;
          cnt_d    = phase_load(gap_q);
          pulses_d = pulses_q - 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = PULSE;
          cnt_d   = phase_load(width_q);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      DONE: begin
        if (!armed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wd_hit) state_d = DONE;

    if (reset_glitcher) begin
      state_d  = IDLE;
      cnt_d    = 32'd0;
      pulses_d = 32'd0;
      wd_d     = 32'd0;
    end
  end

  // Outputs are derived from the next state so they line up with state_q.
  always_comb begin
    case (force_state)
      FORCE_LOW:  glitch_d = 1'b0;
      FORCE_HIGH: glitch_d = 1'b1;
      default:    glitch_d = (state_d == PULSE) ? ~vstart : vstart;
    endcase
    glitched_d = (glitched_q | (state_d == PULSE)) & ~reset_glitcher;
    finished_d = (finished_q | (state_d == DONE)) & ~reset_glitcher;
  end

  assign glitch_out = glitch_q;
  assign glitched   = glitched_q;
  assign finished   = finished_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed self-checking bench for glitch_sequencer; expected waveforms are
// hand-derived cycle offsets relative to the trigger-edge cycle.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_in;
  logic        invert_trigger;
  logic        armed;
  logic        reset_glitcher;
  logic        vstart;
  logic [1:0]  force_state;
  logic [31:0] glitch_delay;
  logic [31:0] glitch_width;
  logic [31:0] glitch_count;
  logic [31:0] glitch_gap;
  logic [31:0] glitch_max;
  logic        glitch_out;
  logic        glitched;
  logic        finished;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glitch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .trigger_in    (trigger_in),
    .invert_trigger(invert_trigger),
    .armed         (armed),
    .reset_glitcher(reset_glitcher),
    .vstart        (vstart),
    .force_state   (force_state),
    .glitch_delay  (glitch_delay),
    .glitch_width  (glitch_width),
    .glitch_count  (glitch_count),
    .glitch_gap    (glitch_gap),
    .glitch_max    (glitch_max),
    .glitch_out    (glitch_out),
    .glitched      (glitched),
    .finished      (finished)
  );

  // Every drive and sample happens 1 ns after a rising clock edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] w,
                               input logic [31:0] c, input logic [31:0] g,
                               input logic [31:0] m);
    glitch_delay = d;
    glitch_width = w;
    glitch_count = c;
    glitch_gap   = g;
    glitch_max   = m;
  endtask

  // Synchronizer plus edge register put trig_edge 3 clocks after the pin moves.
  task automatic fireTrigger();
    trigger_in = 1'b0;
    tick(3);
    trigger_in = 1'b1;
    tick(3);
  endtask

  task automatic clearSequencer();
    armed = 1'b0;
    tick(1);
    reset_glitcher = 1'b1;
    tick(1);
    reset_glitcher = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    trigger_in     = 1'b0;
    invert_trigger = 1'b0;
    armed          = 1'b0;
    reset_glitcher = 1'b0;
    vstart         = 1'b1;
    force_state    = 2'd2;
    applyStimulus(0, 0, 0, 0, 0);

    tick(2);
    checkOutput("rst_out", glitch_out, 1'b0);
    checkOutput("rst_glitched", glitched, 1'b0);
    checkOutput("rst_finished", finished, 1'b0);
    rst = 1'b0;
    tick(1);
    checkOutput("post_rst_vstart1", glitch_out, 1'b1);
    vstart = 1'b0;
    tick(1);
    checkOutput("post_rst_vstart0", glitch_out, 1'b0);

    $display("[TB] scenario: delay 10, width 3, count 2, gap 4");
    applyStimulus(10, 3, 2, 4, 0);
    armed = 1'b1;
    tick(1);
    fireTrigger();
    checkOutput("s1_trig_cycle", glitch_out, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      tick(1);
      if (k == 1) applyStimulus(2, 50, 5, 1, 5);
      checkOutput($sformatf("s1_out_k%0d", k), glitch_out,
                  (k >= 11 && k <= 13) || (k >= 18 && k <= 20));
      checkOutput($sformatf("s1_glitched_k%0d", k), glitched, k >= 11);
      checkOutput($sformatf("s1_finished_k%0d", k), finished, k >= 21);
    end
    armed = 1'b0;
    tick(1);
    checkOutput("s1_finished_sticky", finished, 1'b1);
    reset_glitcher = 1'b1;
    tick(1);
    reset_glitcher = 1'b0;
    checkOutput("s1_clear_glitched", glitched, 1'b0);
    checkOutput("s1_clear_finished", finished, 1'b0);

    $display("[TB] scenario: edge while idle is ignored, then minimal sequence");
    applyStimulus(0, 0, 0, 0, 0);
    trigger_in = 1'b0;
    tick(3);
    trigger_in = 1'b1;
    tick(6);
    checkOutput("s2_idle_edge_out", glitch_out, 1'b0);
    checkOutput("s2_idle_edge_glitched", glitched, 1'b0);
    armed = 1'b1;
    tick(3);
    checkOutput("s2_armed_no_edge", glitched, 1'b0);
    fireTrigger();
    checkOutput("s2_trig_cycle", glitch_out, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      checkOutput($sformatf("s2_out_k%0d", k), glitch_out, k == 1);
      checkOutput($sformatf("s2_finished_k%0d", k), finished, k >= 2);
    end
    clearSequencer();

    $display("[TB] scenario: inverted trigger");
    trigger_in     = 1'b0;
    invert_trigger = 1'b1;
    tick(5);
    applyStimulus(2, 2, 1, 0, 0);
    armed = 1'b1;
    tick(1);
    trigger_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checkOutput($sformatf("s3_rise_ignored_k%0d", k), glitch_out, 1'b0);
    end
    checkOutput("s3_rise_glitched", glitched, 1'b0);
    trigger_in = 1'b0;
    tick(3);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checkOutput($sformatf("s3_out_k%0d", k), glitch_out, k == 3 || k == 4);
      checkOutput($sformatf("s3_finished_k%0d", k), finished, k >= 5);
    end
    clearSequencer();
    invert_trigger = 1'b0;
    tick(4);

    $display("[TB] scenario: watchdog truncates a long pulse");
    vstart = 1'b1;
    tick(1);
    checkOutput("s4_idle_vstart1", glitch_out, 1'b1);
    applyStimulus(5, 100, 1, 0, 20);
    armed = 1'b1;
    tick(1);
    fireTrigger();
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      checkOutput($sformatf("s4_out_k%0d", k), glitch_out, !(k >= 6 && k <= 19));
      checkOutput($sformatf("s4_finished_k%0d", k), finished, k >= 20);
    end
    clearSequencer();

    $display("[TB] scenario: reset_glitcher mid-pulse");
    applyStimulus(1, 10, 1, 0, 0);
    armed = 1'b1;
    tick(1);
    fireTrigger();
    tick(2);
    checkOutput("s5_pulse_k2", glitch_out, 1'b0);
    checkOutput("s5_glitched_k2", glitched, 1'b1);
    tick(1);
    checkOutput("s5_pulse_k3", glitch_out, 1'b0);
    reset_glitcher = 1'b1;
    tick(1);
    reset_glitcher = 1'b0;
    checkOutput("s5_rg_out", glitch_out, 1'b1);
    checkOutput("s5_rg_glitched", glitched, 1'b0);
    checkOutput("s5_rg_finished", finished, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checkOutput($sformatf("s5_held_idle_k%0d", k), glitch_out, 1'b1);
    end
    applyStimulus(0, 1, 1, 0, 0);
    fireTrigger();
    tick(1);
    checkOutput("s5_rearm_pulse", glitch_out, 1'b0);
    checkOutput("s5_rearm_glitched", glitched, 1'b1);
    tick(1);
    checkOutput("s5_rearm_out", glitch_out, 1'b1);
    checkOutput("s5_rearm_finished", finished, 1'b1);
    clearSequencer();

    $display("[TB] scenario: force_state overrides");
    vstart      = 1'b0;
    force_state = 2'd1;
    tick(1);
    checkOutput("s6_force_high", glitch_out, 1'b1);
    force_state = 2'd2;
    tick(1);
    checkOutput("s6_auto_vstart0", glitch_out, 1'b0);
    force_state = 2'd3;
    vstart      = 1'b1;
    tick(1);
    checkOutput("s6_code3_vstart1", glitch_out, 1'b1);
    force_state = 2'd0;
    tick(1);
    checkOutput("s6_force_low", glitch_out, 1'b0);
    applyStimulus(0, 2, 1, 0, 0);
    armed = 1'b1;
    tick(1);
    fireTrigger();
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checkOutput($sformatf("s6_forced_out_k%0d", k), glitch_out, 1'b0);
      checkOutput($sformatf("s6_glitched_k%0d", k), glitched, 1'b1);
      checkOutput($sformatf("s6_finished_k%0d", k), finished, k >= 3);
    end
    force_state = 2'd2;
    tick(1);
    checkOutput("s6_auto_after_done", glitch_out, 1'b1);

    $display("[TB] scenario: asynchronous reset between clock edges");
    rst = 1'b1;
    #2;
    checkOutput("async_rst_out", glitch_out, 1'b0);
    checkOutput("async_rst_glitched", glitched, 1'b0);
    checkOutput("async_rst_finished", finished, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("async_rst_release", glitch_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
